load_sched: RTL
===============

// Module: load_sched
// PURPOSE
//  Load-command scheduler in front of the load buffer. Queues load requests from the decode stage in a small FIFO.
//  Issues them one at a time as a single-cycle ctrl_load_vld pulse, then counts read-data beats until rlast.
//  Reports per-command completion with beat-count check; only one load in flight.
// PARAMETERS
//  DEPTH       4     command FIFO entries (power of 2, >=2)
//  TO_CYCLES   1023  watchdog limit in cycles, used only with LOAD_SCHED_TIMEOUT_EN
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   asynchronous active-low reset
//  idu_ld_vld           in   1   request valid
//  idu_ld_rdy           out  1   request accepted when vld&rdy; = !fifo_full
//  idu_ld_id            in   8   transaction id
//  idu_ld_dram_addr     in   12  DRAM start address
//  idu_ld_len           in   8   burst length-1 (AXI style)
//  idu_ld_size          in   3   beat size
//  idu_ld_str           in   3   stride code, passed through
//  idu_ld_sram_addr     in   12  SRAM destination base
//  ctrl_load_vld        out  1   one-cycle issue pulse to load buffer
//  ctrl_load_id/_dram_addr/_len/_size/_str/_ld_addr  out 8/12/8/3/3/12  issued descriptor, held stable while busy
//  ctrl_sram_rvld       in   1   read beat valid (observed, not consumed)
//  ctrl_sram_rlast      in   1   last beat, qualified by rvld
//  ld_done_vld          out  1   one-cycle completion pulse
//  ld_done_id           out  8   id of completed command
//  ld_done_err          out  1   beat count != len+1 (or timeout)
//  ld_busy              out  1   state != IDLE or fifo not empty
// BEHAVIOUR
//  Reset: all outputs 0 except idu_ld_rdy=1; FIFO empty; state IDLE; counters 0.
//  FIFO: push on idu_ld_vld&idu_ld_rdy; pop on IDLE->ISSUE. Push and pop in the same cycle on a full FIFO are not allowed (rdy=0).
//  Pointers are log2(DEPTH)+1 bits with a wrap bit: full when MSBs differ and LSBs are equal; empty when pointers are equal.
//  FSM:
//   IDLE  : if !empty -> ISSUE; latch head descriptor into ctrl_load_* regs and pop.
//   ISSUE : ctrl_load_vld=1 this cycle only; beat_cnt<=0; -> WAIT.
//   WAIT  : each rvld increments beat_cnt (9 bit, saturates at 511).
//           On rvld&rlast -> DONE; err = (beat_cnt+1 != len+1).
//           rvld in ISSUE is counted (same rules as WAIT).
//   DONE  : ld_done_vld=1, ld_done_id=latched id, ld_done_err; -> IDLE.
//  Latency: request into an empty idle FIFO -> ctrl_load_vld 2 cycles after acceptance. rlast -> ld_done_vld 1 cycle later.
//  Min gap between issue pulses: 3 cycles plus the beat count.
//  rvld seen in IDLE or DONE: ignored, no state change.
//  rvld without rlast after len+1 beats: keep counting; err is flagged when rlast finally arrives.
//  Reset mid-burst: FSM to IDLE, FIFO flushed, no done pulse.
// CONFIGURATION
//  LOAD_SCHED_TIMEOUT_EN defined: a 10-bit wdog counter runs in WAIT and clears on every rvld.
//   When wdog reaches TO_CYCLES -> DONE with ld_done_err=1.
//   Beats arriving later for that id are ignored (IDLE rule).
//  LOAD_SCHED_TIMEOUT_EN undefined: no wdog logic; WAIT exits only on rlast.
// STRUCTURE
//  Shared package load_pkg: FSM state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DONE=2'b11);
//   widths ID_W=8, DADDR_W=12, LEN_W=8, SIZE_W=3, STR_W=3, SADDR_W=12; the packed descriptor type (46 bits).
//  Sub-module: load_cmd_fifo (parameterised DEPTH x 46-bit sync FIFO, async reset, full/empty).
//  FSM, beat counter and wdog stay in load_sched.
// TESTING
//  1 Single cmd id=0x05 len=3, drive 4 beats with rlast on the 4th -> one issue pulse; done id=0x05 err=0.
//  2 Push 5 cmds back-to-back, DEPTH=4, sched stalled in WAIT -> rdy drops after 4th push (plus the one in flight).
//    All complete in push order.
//  3 len=3 but rlast on beat 2 -> ld_done_err=1; next cmd still issues normally.
//  4 rvld pulses while IDLE, no cmd queued -> no state change, no done, beat_cnt stays 0.
//  5 Assert rst_n=0 in WAIT with 2 cmds queued -> outputs reset, rdy=1, busy=0, no done pulse.
//  6 (TIMEOUT_EN) TO_CYCLES=16, issue cmd, send no beats -> done err=1 exactly 16 cycles into WAIT.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load-command scheduler.
//   - state_t      : scheduler FSM encoding (IDLE/ISSUE/WAIT/DONE)
//   - *_W          : descriptor field widths
//   - load_desc_t  : packed 46-bit load descriptor as stored in the command FIFO
//   - DESC_W       : width of load_desc_t
package load_pkg;

    localparam int ID_W    = 8;
    localparam int DADDR_W = 12;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int STR_W   = 3;
    localparam int SADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [DADDR_W-1:0] dram_addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [STR_W-1:0]   str;
        logic [SADDR_W-1:0] sram_addr;
    } load_desc_t;

    localparam int DESC_W = $bits(load_desc_t);

endpackage

// File: rtl/load_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of DESC_W bits, async active-low reset.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   push, din   write request and data (ignored while full)
//   pop, dout   read request (ignored while empty); dout shows the head entry
//   full, empty status flags
// Pointers carry an extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module load_cmd_fifo
    import load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DESC_W-1:0] din,
    input  logic              pop,
    output logic [DESC_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DESC_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/load_sched.sv
// Load-command scheduler in front of the load buffer.
// Queues decode-stage load requests, issues them one at a time as a single
// cycle ctrl_load_vld pulse, counts read beats until rlast and reports a
// completion with a beat-count check. Only one load is in flight.
//
// Handshake: a request is accepted on every clock edge where idu_ld_vld and
// idu_ld_rdy are both high; idu_ld_rdy depends only on FIFO fullness, never on
// idu_ld_vld. ctrl_load_vld and ld_done_vld are unacknowledged one-cycle
// pulses; ctrl_sram_rvld/rlast are observed only.
//
// Ports:
//   clk, rst_n                     clock / asynchronous active-low reset
//   idu_ld_vld/_rdy                request handshake
//   idu_ld_id/_dram_addr/_len/_size/_str/_sram_addr   request descriptor
//   ctrl_load_vld                  issue pulse
//   ctrl_load_id/_dram_addr/_len/_size/_str/_ld_addr  issued descriptor (held)
//   ctrl_sram_rvld/_rlast          read beat observation
//   ld_done_vld/_id/_err           completion report
//   ld_busy                        FSM not idle or commands queued
//   dbg_state                      current FSM state (state_t encoding)
//
// Build option: LOAD_SCHED_TIMEOUT_EN adds a watchdog (parameter TO_CYCLES)
// that ends a WAIT with an error after TO_CYCLES beat-less cycles.
module load_sched
    import load_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef LOAD_SCHED_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = 1023
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idu_ld_vld,
    output logic        idu_ld_rdy,
    input  logic [7:0]  idu_ld_id,
    input  logic [11:0] idu_ld_dram_addr,
    input  logic [7:0]  idu_ld_len,
    input  logic [2:0]  idu_ld_size,
    input  logic [2:0]  idu_ld_str,
    input  logic [11:0] idu_ld_sram_addr,
    output logic        ctrl_load_vld,
    output logic [7:0]  ctrl_load_id,
    output logic [11:0] ctrl_load_dram_addr,
    output logic [7:0]  ctrl_load_len,
    output logic [2:0]  ctrl_load_size,
    output logic [2:0]  ctrl_load_str,
    output logic [11:0] ctrl_load_ld_addr,
    input  logic        ctrl_sram_rvld,
    input  logic        ctrl_sram_rlast,
    output logic        ld_done_vld,
    output logic [7:0]  ld_done_id,
    output logic        ld_done_err,
    output logic        ld_busy,
    output logic [1:0]  dbg_state
);

    state_t     state;
    state_t     state_nxt;
    load_desc_t req;
    load_desc_t head;
    load_desc_t cur;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       in_flight;
    logic       last_beat;
    logic       timeout;
    logic       len_err;
    logic       err_q;
    logic [8:0] beat_cnt;
    logic [8:0] cnt_base;
    logic [8:0] beat_inc;

    assign req = '{id: idu_ld_id, dram_addr: idu_ld_dram_addr, len: idu_ld_len,
                   size: idu_ld_size, str: idu_ld_str, sram_addr: idu_ld_sram_addr};

    assign idu_ld_rdy = !fifo_full;
    assign push       = idu_ld_vld && !fifo_full;

    load_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (req),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Beats are counted in ISSUE as well as WAIT; ISSUE counts from zero
    // because beat_cnt still holds the previous command's total there.
    assign in_flight = (state == ISSUE) || (state == WAIT);
    assign last_beat = in_flight && ctrl_sram_rvld && ctrl_sram_rlast;
    assign cnt_base  = (state == ISSUE) ? 9'd0 : beat_cnt;
    assign beat_inc  = (cnt_base == 9'd511) ? cnt_base : cnt_base + 9'd1;
    assign len_err   = ({1'b0, beat_inc} != ({2'b00, cur.len} + 10'd1));

`ifdef LOAD_SCHED_TIMEOUT_EN
    localparam logic [9:0] TO_LIM = 10'(TO_CYCLES);
    logic [9:0] wdog;

    // Fires on the TO_CYCLES-th consecutive WAIT cycle without a beat.
    assign timeout = (state == WAIT) && !ctrl_sram_rvld && ((wdog + 10'd1) == TO_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == ISSUE || ctrl_sram_rvld) begin
            wdog <= '0;
        end else if (state == WAIT) begin
            wdog <= wdog + 10'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ISSUE;
                    pop       = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                if (last_beat || timeout) state_nxt = DONE;
                else                      state_nxt = WAIT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop) cur <= head;
            if (in_flight) begin
                if (ctrl_sram_rvld)      beat_cnt <= beat_inc;
                else if (state == ISSUE) beat_cnt <= '0;
            end
            if (last_beat)    err_q <= len_err;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign ctrl_load_vld       = (state == ISSUE);
    assign ctrl_load_id        = cur.id;
    assign ctrl_load_dram_addr = cur.dram_addr;
    assign ctrl_load_len       = cur.len;
    assign ctrl_load_size      = cur.size;
    assign ctrl_load_str       = cur.str;
    assign ctrl_load_ld_addr   = cur.sram_addr;

    assign ld_done_vld = (state == DONE);
    assign ld_done_id  = (state == DONE) ? cur.id : 8'd0;
    assign ld_done_err = (state == DONE) && err_q;
    assign ld_busy     = (state != IDLE) || !fifo_empty;
    assign dbg_state   = state;

endmodule
